// File: rtl/blur3x3_pkg.sv
// Shared constants, pixel type and small arithmetic helpers for the 3x3 RGB box blur.
package blur3x3_pkg;

    localparam logic [31:0] REG_WIDTH  = 32'h0000_0000;
    localparam logic [31:0] REG_HEIGHT = 32'h0000_0004;
    localparam logic [31:0] REG_STATUS = 32'h0000_0008;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int          MIN_DIM    = 3;
    localparam logic [15:0] DEF_WIDTH  = 16'd640;
    localparam logic [15:0] DEF_HEIGHT = 16'd480;

    typedef struct packed {
        logic [7:0] c2;
        logic [7:0] c1;
        logic [7:0] c0;
    } pix_t;

    // floor(s/9) for s <= 2295: 3641/2^15 overshoots 1/9 by too little to cross an integer.
    function automatic logic [7:0] div9(input logic [11:0] s);
        return 8'(({12'b0, s} * 24'd3641) >> 15);
    endfunction

    function automatic logic [15:0] strb_merge(input logic [15:0] old_v,
                                               input logic [15:0] wr_v,
                                               input logic [1:0]  strb);
        logic [15:0] r;
        r = old_v;
        if (strb[0]) r[7:0]  = wr_v[7:0];
        if (strb[1]) r[15:8] = wr_v[15:8];
        return r;
    endfunction

endpackage

// File: rtl/blur_linebuf.sv
// Two row memories plus two registered window columns; the current column is
// formed combinationally so the full 3x3 window is available on the accepting beat.
module blur_linebuf
    import blur3x3_pkg::*;
#(
    parameter int MAX_WIDTH = 1024,
    parameter int AW        = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en_i,
    input  logic [AW-1:0]        col_i,
    input  pix_t                 pix_i,
    output pix_t [2:0][2:0]      win_o      // [row][col]; row 2 = y, col 2 = x
);

    pix_t row1_mem [MAX_WIDTH];   // row y-1
    pix_t row2_mem [MAX_WIDTH];   // row y-2
    pix_t up1, up2;
    pix_t [2:0][1:0] cols_q;      // [row][col]; col 0 = x-2, col 1 = x-1

    assign up1 = row1_mem[col_i];
    assign up2 = row2_mem[col_i];

    always_ff @(posedge clk) begin
        if (en_i) begin
            row1_mem[col_i] <= pix_i;
            row2_mem[col_i] <= up1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cols_q <= '0;
        end else if (en_i) begin
            for (int r = 0; r < 3; r++) cols_q[r][0] <= cols_q[r][1];
            cols_q[0][1] <= up2;
            cols_q[1][1] <= up1;
            cols_q[2][1] <= pix_i;
        end
    end

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            win_o[r][0] = cols_q[r][0];
            win_o[r][1] = cols_q[r][1];
        end
        win_o[0][2] = up2;
        win_o[1][2] = up1;
        win_o[2][2] = pix_i;
    end

endmodule

// File: rtl/blur3x3_rgb_stream.sv
// Streaming 3x3 box blur: AXI-Lite frame-size registers, raster counters,
// per-channel window sum / 9 and a one-entry output register.
module blur3x3_rgb_stream
    import blur3x3_pkg::*;
#(
    parameter int MAX_WIDTH = 1024,
    parameter int ADDR_W    = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ARADDR,
    input  logic              ARVALID,
    output logic              ARREADY,
    output logic [31:0]       RDATA,
    output logic [1:0]        RRESP,
    output logic              RVALID,
    input  logic              RREADY,
    input  logic [ADDR_W-1:0] AWADDR,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [31:0]       WDATA,
    input  logic [3:0]        WSTRB,
    input  logic              WVALID,
    output logic              WREADY,
    output logic [1:0]        BRESP,
    output logic              BVALID,
    input  logic              BREADY,
    input  logic [7:0]        in_1_TDATA_0_0_0,
    input  logic [7:0]        in_1_TDATA_0_0_1,
    input  logic [7:0]        in_1_TDATA_0_0_2,
    input  logic              in_1_TVALID,
    output logic              in_1_TREADY,
    input  logic              in_1_TLAST,
    output logic [7:0]        hw_output_1_TDATA_0_0_0,
    output logic [7:0]        hw_output_1_TDATA_0_0_1,
    output logic [7:0]        hw_output_1_TDATA_0_0_2,
    output logic              hw_output_1_TVALID,
    input  logic              hw_output_1_TREADY,
    output logic              hw_output_1_TLAST
);

    localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

    // ---------------- AXI-Lite register file ----------------
    logic        awready_q, bvalid_q, arready_q, rvalid_q;
    logic [1:0]  bresp_q, rresp_q;
    logic [31:0] rdata_q, rdata_d;
    logic [15:0] width_q, width_d, height_q, height_d;
    logic        w_hs, r_hs;
    logic        dim_err_q, dim_err_d, busy;

    function automatic logic is_mapped(input logic [ADDR_W-1:0] a);
        return (a == ADDR_W'(REG_WIDTH)) || (a == ADDR_W'(REG_HEIGHT)) ||
               (a == ADDR_W'(REG_STATUS));
    endfunction

    assign w_hs = awready_q && AWVALID && WVALID;
    assign r_hs = arready_q && ARVALID;

    always_comb begin
        width_d  = width_q;
        height_d = height_q;
        if (w_hs && AWADDR == ADDR_W'(REG_WIDTH))
            width_d = strb_merge(width_q, WDATA[15:0], WSTRB[1:0]);
        if (w_hs && AWADDR == ADDR_W'(REG_HEIGHT))
            height_d = strb_merge(height_q, WDATA[15:0], WSTRB[1:0]);
    end

    always_comb begin
        rdata_d = '0;
        if (ARADDR == ADDR_W'(REG_WIDTH))       rdata_d = {16'b0, width_q};
        else if (ARADDR == ADDR_W'(REG_HEIGHT)) rdata_d = {16'b0, height_q};
        else if (ARADDR == ADDR_W'(REG_STATUS)) rdata_d = {30'b0, dim_err_q, busy};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            width_q   <= DEF_WIDTH;
            height_q  <= DEF_HEIGHT;
        end else begin
            awready_q <= AWVALID && WVALID && !bvalid_q && !awready_q;
            arready_q <= ARVALID && !rvalid_q && !arready_q;
            width_q   <= width_d;
            height_q  <= height_d;
            if (w_hs) begin
                bvalid_q <= 1'b1;
                bresp_q  <= is_mapped(AWADDR) ? RESP_OKAY : RESP_SLVERR;
            end else if (bvalid_q && BREADY) begin
                bvalid_q <= 1'b0;
            end
            if (r_hs) begin
                rvalid_q <= 1'b1;
                rresp_q  <= is_mapped(ARADDR) ? RESP_OKAY : RESP_SLVERR;
                rdata_q  <= rdata_d;
            end else if (rvalid_q && RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign AWREADY = awready_q;
    assign WREADY  = awready_q;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;
    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RRESP   = rresp_q;
    assign RDATA   = rdata_q;

    // ---------------- Raster counters and frame latch ----------------
    logic [15:0] x_q, x_d, y_q, y_d, fw_q, fh_q, fw, fh;
    logic        fok_q, first, dims_ok, frame_ok, last_x, last_y, accept, emit;
    logic        ovalid_q, ovalid_d, olast_q, olast_d;
    pix_t        odata_q, odata_d, in_pix, blur;
    pix_t [2:0][2:0] win;
    logic [11:0] s0, s1, s2;

    assign in_pix = '{c2: in_1_TDATA_0_0_2, c1: in_1_TDATA_0_0_1, c0: in_1_TDATA_0_0_0};

    // Pixel (0,0) sees the live registers; the rest of the frame uses the latched copy.
    assign first    = (x_q == '0) && (y_q == '0);
    assign busy     = !first;
    assign fw       = first ? width_q  : fw_q;
    assign fh       = first ? height_q : fh_q;
    assign dims_ok  = (fw >= 16'(MIN_DIM)) && (fh >= 16'(MIN_DIM)) &&
                      ({1'b0, fw} <= 17'(MAX_WIDTH));
    assign frame_ok = first ? dims_ok : fok_q;
    assign last_x   = ({1'b0, x_q} + 17'd1) >= {1'b0, fw};
    assign last_y   = ({1'b0, y_q} + 17'd1) >= {1'b0, fh};

    assign in_1_TREADY = reset && (!ovalid_q || hw_output_1_TREADY);
    assign accept      = in_1_TVALID && in_1_TREADY;
    assign emit        = accept && frame_ok && (x_q >= 16'd2) && (y_q >= 16'd2);

    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        dim_err_d = dim_err_q;
        if (accept) begin
            if (last_x) begin
                x_d = '0;
                y_d = last_y ? '0 : y_q + 16'd1;
            end else begin
                x_d = x_q + 16'd1;
            end
            if (first) dim_err_d = !dims_ok;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x_q       <= '0;
            y_q       <= '0;
            fw_q      <= DEF_WIDTH;
            fh_q      <= DEF_HEIGHT;
            fok_q     <= 1'b0;
            dim_err_q <= 1'b0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            dim_err_q <= dim_err_d;
            if (accept && first) begin
                fw_q  <= width_q;
                fh_q  <= height_q;
                fok_q <= dims_ok;
            end
        end
    end

    // ---------------- Window, sum and divide ----------------
    blur_linebuf #(.MAX_WIDTH(MAX_WIDTH), .AW(AW)) u_linebuf (
        .clk   (clock),
        .rst_n (reset),
        .en_i  (accept && frame_ok),
        .col_i (x_q[AW-1:0]),
        .pix_i (in_pix),
        .win_o (win)
    );

    always_comb begin
        s0 = '0;
        s1 = '0;
        s2 = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                s0 = s0 + 12'(win[r][c].c0);
                s1 = s1 + 12'(win[r][c].c1);
                s2 = s2 + 12'(win[r][c].c2);
            end
        end
        blur = '{c2: div9(s2), c1: div9(s1), c0: div9(s0)};
    end

    // ---------------- Output register ----------------
    always_comb begin
        ovalid_d = ovalid_q;
        odata_d  = odata_q;
        olast_d  = olast_q;
        if (emit) begin
            ovalid_d = 1'b1;
            odata_d  = blur;
            olast_d  = last_x && last_y;
        end else if (hw_output_1_TREADY) begin
            ovalid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ovalid_q <= 1'b0;
            odata_q  <= '0;
            olast_q  <= 1'b0;
        end else begin
            ovalid_q <= ovalid_d;
            odata_q  <= odata_d;
            olast_q  <= olast_d;
        end
    end

    assign hw_output_1_TVALID      = ovalid_q;
    assign hw_output_1_TLAST       = olast_q;
    assign hw_output_1_TDATA_0_0_0 = odata_q.c0;
    assign hw_output_1_TDATA_0_0_1 = odata_q.c1;
    assign hw_output_1_TDATA_0_0_2 = odata_q.c2;

    logic unused_ok;
    assign unused_ok = ^{in_1_TLAST, WSTRB[3:2], WDATA[31:16]};

endmodule

// File: tb/tb_blur3x3_rgb_stream.sv
// Randomized bench for blur3x3_rgb_stream with a frame-level reference model.
module tb_blur3x3_rgb_stream;

    localparam int MAXW = 64;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] ARADDR = '0, AWADDR = '0, WDATA = '0, RDATA;
    logic        ARVALID = 1'b0, AWVALID = 1'b0, WVALID = 1'b0, BREADY = 1'b0, RREADY = 1'b0;
    logic [3:0]  WSTRB = '0;
    logic        ARREADY, AWREADY, WREADY, BVALID, RVALID;
    logic [1:0]  BRESP, RRESP;
    logic [7:0]  id0 = '0, id1 = '0, id2 = '0, od0, od1, od2;
    logic        in_valid = 1'b0, in_ready, in_last = 1'b0;
    logic        out_valid, out_ready = 1'b1, out_last;

    int errors = 0;
    int checks = 0;

    blur3x3_rgb_stream #(.MAX_WIDTH(MAXW), .ADDR_W(32)) dut (
        .clock(clock), .reset(reset),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .in_1_TDATA_0_0_0(id0), .in_1_TDATA_0_0_1(id1), .in_1_TDATA_0_0_2(id2),
        .in_1_TVALID(in_valid), .in_1_TREADY(in_ready), .in_1_TLAST(in_last),
        .hw_output_1_TDATA_0_0_0(od0), .hw_output_1_TDATA_0_0_1(od1),
        .hw_output_1_TDATA_0_0_2(od2),
        .hw_output_1_TVALID(out_valid), .hw_output_1_TREADY(out_ready),
        .hw_output_1_TLAST(out_last)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        logic ok;
        ok = 1'b0;
        @(negedge clock);
        AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1'b1; WVALID = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (AWREADY && WREADY) begin ok = 1'b1; break; end
        end
        chk("aw_ready", {31'b0, ok}, 32'd1);
        @(posedge clock); #1;
        AWVALID = 1'b0; WVALID = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (BVALID) begin ok = 1'b1; break; end
        end
        chk("b_valid", {31'b0, ok}, 32'd1);
        resp = BRESP;
        BREADY = 1'b1;
        @(posedge clock); #1;
        BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        logic ok;
        ok = 1'b0;
        @(negedge clock);
        ARADDR = a; ARVALID = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (ARREADY) begin ok = 1'b1; break; end
        end
        chk("ar_ready", {31'b0, ok}, 32'd1);
        @(posedge clock); #1;
        ARVALID = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (RVALID) begin ok = 1'b1; break; end
        end
        chk("r_valid", {31'b0, ok}, 32'd1);
        d = RDATA; resp = RRESP;
        RREADY = 1'b1;
        @(posedge clock); #1;
        RREADY = 1'b0;
    endtask

    task automatic set_dims(input int w, input int h);
        logic [1:0] r;
        axi_write(32'h0, w, 4'hf, r);
        axi_write(32'h4, h, 4'hf, r);
    endtask

    // pmode: 0 flat 0x40, 1 ramp x+4y/255/0, 2 random. smode: 0 ready, 1 one-in-three, 2 random.
    task automatic run_frame(input int w, input int h, input int pmode, input int smode,
                             input int vmode, input int abort_at);
        logic [7:0]  p0[], p1[], p2[];
        logic [24:0] expq[$];
        logic [24:0] obs, held;
        logic        held_v, ordy;
        int          sent, got, n_exp, cyc, s0, s1, s2;
        p0 = new[w*h]; p1 = new[w*h]; p2 = new[w*h];
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++) begin
                case (pmode)
                    0: begin p0[y*w+x] = 8'h40; p1[y*w+x] = 8'h40; p2[y*w+x] = 8'h40; end
                    1: begin p0[y*w+x] = 8'(x + 4*y); p1[y*w+x] = 8'd255; p2[y*w+x] = 8'd0; end
                    default: begin
                        p0[y*w+x] = 8'($urandom); p1[y*w+x] = 8'($urandom); p2[y*w+x] = 8'($urandom);
                    end
                endcase
            end
        if (w >= 3 && h >= 3 && w <= MAXW)
            for (int y = 2; y < h; y++)
                for (int x = 2; x < w; x++) begin
                    s0 = 0; s1 = 0; s2 = 0;
                    for (int dy = 0; dy < 3; dy++)
                        for (int dx = 0; dx < 3; dx++) begin
                            s0 += p0[(y-dy)*w + x-dx];
                            s1 += p1[(y-dy)*w + x-dx];
                            s2 += p2[(y-dy)*w + x-dx];
                        end
                    expq.push_back({(x == w-1 && y == h-1), 8'(s2/9), 8'(s1/9), 8'(s0/9)});
                end
        n_exp = expq.size();
        sent = 0; got = 0; cyc = 0; held_v = 1'b0; held = '0;
        while ((sent < w*h || expq.size() > 0) && cyc < 5000) begin
            @(negedge clock);
            cyc++;
            if (abort_at >= 0 && sent == abort_at) begin
                chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
                reset = 1'b0; in_valid = 1'b0;
                #1;
                chk("rst_tvalid", {31'b0, out_valid}, 32'd0);
                chk("rst_tready", {31'b0, in_ready}, 32'd0);
                repeat (2) @(negedge clock);
                reset = 1'b1; out_ready = 1'b1;
                return;
            end
            case (smode)
                0:       ordy = 1'b1;
                1:       ordy = (cyc % 3 == 0);
                default: ordy = 1'($urandom_range(0, 1));
            endcase
            out_ready = ordy;
            if (sent < w*h && (vmode == 0 || $urandom_range(0, 3) != 0)) begin
                id0 = p0[sent]; id1 = p1[sent]; id2 = p2[sent]; in_valid = 1'b1;
            end else begin
                id0 = 8'($urandom); id1 = 8'($urandom); id2 = 8'($urandom); in_valid = 1'b0;
            end
            in_last = 1'($urandom_range(0, 1));
            #1;
            obs = {out_last, od2, od1, od0};
            if (held_v) begin
                chk("valid_hold", {31'b0, out_valid}, 32'd1);
                chk("stall_hold", obs, held);
            end
            held_v = 1'b0;
            if (out_valid) begin
                if (ordy) begin
                    got++;
                    if (expq.size() == 0) chk("out_count", got, n_exp);
                    else chk("out_px", obs, expq.pop_front());
                end else begin
                    held_v = 1'b1; held = obs;
                end
            end
            if (in_valid && in_ready) sent++;
        end
        @(negedge clock);
        in_valid = 1'b0; out_ready = 1'b1;
        chk("frame_done", {31'b0, cyc < 5000}, 32'd1);
        chk("in_count", sent, w*h);
        chk("out_count", got, n_exp);
        repeat (2) @(negedge clock);
        chk("no_extra", {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        int          w, h;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_axi_rdy", {ARREADY, AWREADY, WREADY, BVALID, RVALID}, 32'd0);
        chk("rst_resp", {BRESP, RRESP}, 32'd0);
        chk("rst_rdata", RDATA, 32'd0);
        chk("rst_stream", {out_valid, out_last, od2, od1, od0, in_ready}, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        axi_read(32'h0, d, r); chk("def_width", d, 32'd640);
        axi_read(32'h4, d, r); chk("def_height", d, 32'd480);

        axi_write(32'h0, 32'd4, 4'hf, r); chk("bresp_w", r, 32'd0);
        axi_write(32'h4, 32'd4, 4'hf, r); chk("bresp_h", r, 32'd0);
        axi_read(32'h0, d, r); chk("rd_width", d, 32'd4); chk("rresp_w", r, 32'd0);
        axi_read(32'h4, d, r); chk("rd_height", d, 32'd4); chk("rresp_h", r, 32'd0);
        axi_read(32'h20, d, r); chk("rresp_bad", r, 32'd2);
        axi_write(32'h20, 32'd9, 4'hf, r); chk("bresp_bad", r, 32'd2);
        axi_write(32'h8, 32'd3, 4'hf, r); chk("bresp_status", r, 32'd0);
        axi_write(32'h0, 32'h0000_abcd, 4'h1, r);
        axi_read(32'h0, d, r); chk("strobe_lo", d, 32'h0000_00cd);
        axi_write(32'h0, 32'd4, 4'hf, r);
        axi_read(32'h0, d, r); chk("width_kept", d, 32'd4);

        run_frame(4, 4, 0, 0, 0, -1);
        run_frame(4, 4, 1, 0, 0, -1);
        run_frame(4, 4, 1, 1, 0, -1);
        axi_read(32'h8, d, r); chk("status_ok", d, 32'd0);

        set_dims(2, 4);
        run_frame(2, 4, 2, 2, 1, -1);
        axi_read(32'h8, d, r); chk("dim_err_set", d & 32'd2, 32'd2);
        set_dims(4, 4);
        run_frame(4, 4, 2, 0, 0, -1);
        axi_read(32'h8, d, r); chk("dim_err_clr", d & 32'd2, 32'd0);

        set_dims(MAXW + 1, 3);
        run_frame(MAXW + 1, 3, 2, 0, 1, -1);
        axi_read(32'h8, d, r); chk("dim_err_wide", d & 32'd2, 32'd2);
        set_dims(3, 3);
        run_frame(3, 3, 2, 2, 1, -1);

        for (int k = 0; k < 4; k++) begin
            w = $urandom_range(3, 12);
            h = $urandom_range(3, 7);
            set_dims(w, h);
            run_frame(w, h, 2, 2, 1, -1);
        end

        set_dims(4, 4);
        run_frame(4, 4, 1, 0, 0, 11);
        axi_read(32'h0, d, r); chk("rst_width", d, 32'd640);
        axi_read(32'h4, d, r); chk("rst_height", d, 32'd480);
        set_dims(4, 4);
        run_frame(4, 4, 1, 1, 1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
